// File: rtl/uart_alu_pkg.sv
// Shared types for the UART-to-ALU receive path.
// Opcodes, parser states and the operand beat bundle.
package uart_alu_pkg;

    typedef enum logic [7:0] {
        OP_ADD = 8'h10,
        OP_MUL = 8'h11
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RSVD,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_DRAIN
    } parser_state_e;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  opcode;
        logic        first;
        logic        last;
    } op_beat_t;

    function automatic logic is_known_op(input logic [7:0] op);
        return (op == OP_ADD) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/uart_idle_timer.sv
// Idle-cycle counter with clear/enable.
// Saturates at CYCLES and flags expiry.
module uart_idle_timer #(
    parameter int CYCLES = 100000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(CYCLES + 1);

    logic [W-1:0] cnt_q;

    assign expired = (cnt_q == W'(CYCLES));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/alu_packet_parser.sv
// Decodes host command packets from the UART byte stream
// into tagged 32-bit operand beats for the ALU.
module alu_packet_parser
    import uart_alu_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter logic [15:0] MAX_LEN        = 16'hFFFF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [31:0] op_data_o,
    output logic [7:0]  op_opcode_o,
    output logic        op_first_o,
    output logic        op_last_o,
    output logic        op_valid_o,
    input  logic        op_ready_i,
    output logic        busy_o,
    output logic        err_opcode_o,
    output logic        err_timeout_o
);

    parser_state_e state_q;
    logic [7:0]    opcode_q;
    logic [15:0]   len_q;
    logic [15:0]   op_cnt_q;
    logic [1:0]    byte_idx_q;
    logic [23:0]   shift_q;
    logic [17:0]   drain_q;
    op_beat_t      beat_q;
    logic          valid_q;
    logic          err_op_q;
    logic          err_to_q;

    logic        stall;
    logic        xfer;
    logic        expired;
    logic        timeout;
    logic [15:0] len_in;
    logic [15:0] op_cnt_nx;
    logic        len_bad;

    // Only the byte that would overwrite an unaccepted beat is held off.
    assign stall = (state_q == S_DATA) && (byte_idx_q == 2'd3)
                && valid_q && !op_ready_i;
    assign xfer      = rx_valid_i && !stall;
    assign timeout   = expired && (state_q != S_IDLE);
    assign len_in    = {rx_data_i, len_q[7:0]};
    assign op_cnt_nx = op_cnt_q + 16'd1;
    assign len_bad   = !is_known_op(opcode_q)
                    || ({1'b0, len_in} > {1'b0, MAX_LEN});

    uart_idle_timer #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear   (xfer || (state_q == S_IDLE)),
        .enable  (!stall),
        .expired (expired)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            opcode_q   <= '0;
            len_q      <= '0;
            op_cnt_q   <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            drain_q    <= '0;
            beat_q     <= '0;
            valid_q    <= 1'b0;
            err_op_q   <= 1'b0;
            err_to_q   <= 1'b0;
        end else begin
            err_op_q <= 1'b0;
            err_to_q <= 1'b0;
            if (op_ready_i) begin
                valid_q <= 1'b0;
            end
            if (xfer) begin
                unique case (state_q)
                    S_IDLE: begin
                        opcode_q <= rx_data_i;
                        state_q  <= S_RSVD;
                    end
                    S_RSVD: begin
                        state_q <= S_LEN_LO;
                    end
                    S_LEN_LO: begin
                        len_q[7:0] <= rx_data_i;
                        state_q    <= S_LEN_HI;
                    end
                    S_LEN_HI: begin
                        len_q[15:8] <= rx_data_i;
                        op_cnt_q    <= '0;
                        byte_idx_q  <= '0;
                        drain_q     <= {len_in, 2'b00};
                        if (len_in == 16'd0) begin
                            err_op_q <= 1'b1;
                            state_q  <= S_IDLE;
                        end else if (len_bad) begin
                            err_op_q <= 1'b1;
                            state_q  <= S_DRAIN;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        byte_idx_q <= byte_idx_q + 2'd1;
                        shift_q    <= {rx_data_i, shift_q[23:8]};
                        if (byte_idx_q == 2'd3) begin
                            op_cnt_q <= op_cnt_nx;
                            valid_q  <= 1'b1;
                            beat_q   <= '{
                                data:   {rx_data_i, shift_q},
                                opcode: opcode_q,
                                first:  (op_cnt_nx == 16'd1),
                                last:   (op_cnt_nx == len_q)
                            };
                            if (op_cnt_nx == len_q) begin
                                state_q <= S_IDLE;
                            end
                        end
                    end
                    S_DRAIN: begin
                        drain_q <= drain_q - 18'd1;
                        if (drain_q == 18'd1) begin
                            state_q <= S_IDLE;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end else if (timeout) begin
                state_q  <= S_IDLE;
                err_to_q <= 1'b1;
            end
        end
    end

    assign rx_ready_o    = !stall;
    assign op_data_o     = beat_q.data;
    assign op_opcode_o   = beat_q.opcode;
    assign op_first_o    = beat_q.first;
    assign op_last_o     = beat_q.last;
    assign op_valid_o    = valid_q;
    assign busy_o        = (state_q != S_IDLE);
    assign err_opcode_o  = err_op_q;
    assign err_timeout_o = err_to_q;

endmodule

// File: tb/tb_alu_packet_parser.sv
// Scoreboard bench for alu_packet_parser.
// Bytes driven from a queue; beats checked on acceptance.
module tb_alu_packet_parser;
    import uart_alu_pkg::*;

    localparam int          TO   = 40;
    localparam logic [15:0] MAXL = 16'd8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [31:0] op_data;
    logic [7:0]  op_opcode;
    logic        op_first;
    logic        op_last;
    logic        op_valid;
    logic        op_ready = 1'b1;
    logic        busy;
    logic        err_op;
    logic        err_to;

    always #5 clk = ~clk;

    alu_packet_parser #(
        .TIMEOUT_CYCLES (TO),
        .MAX_LEN        (MAXL)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .rx_data_i     (rx_data),
        .rx_valid_i    (rx_valid),
        .rx_ready_o    (rx_ready),
        .op_data_o     (op_data),
        .op_opcode_o   (op_opcode),
        .op_first_o    (op_first),
        .op_last_o     (op_last),
        .op_valid_o    (op_valid),
        .op_ready_i    (op_ready),
        .busy_o        (busy),
        .err_opcode_o  (err_op),
        .err_timeout_o (err_to)
    );

    int       checks = 0;
    int       failures = 0;
    op_beat_t sb[$];
    logic [7:0] tx_q[$];
    bit       tx_done;
    int       n_err_op;
    int       n_err_to;
    int       to_delay;
    int       since_done;
    int       stall_cycles;

    task automatic add_hdr(input logic [7:0] op, input logic [15:0] len);
        tx_q.push_back(op);
        tx_q.push_back(8'h00);
        tx_q.push_back(len[7:0]);
        tx_q.push_back(len[15:8]);
    endtask

    task automatic add_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) tx_q.push_back(w[8*i +: 8]);
    endtask

    task automatic exp_beat(input logic [31:0] d, input logic [7:0] op,
                            input logic f, input logic l);
        op_beat_t b;
        b.data = d;
        b.opcode = op;
        b.first = f;
        b.last = l;
        sb.push_back(b);
    endtask

    // Called at a negedge; returns at the negedge after the transfer.
    task automatic send_byte(input logic [7:0] b);
        bit r;
        rx_data = b;
        rx_valid = 1'b1;
        for (int w = 0; w < 200; w++) begin
            #1;
            r = rx_ready;
            @(negedge clk);
            if (r) begin
                rx_valid = 1'b0;
                return;
            end
            stall_cycles++;
        end
        checks++;
        failures++;
        $display("FAIL send_byte: rx_ready stuck 0 for byte %h", b);
        rx_valid = 1'b0;
    endtask

    task automatic drive_all();
        while (tx_q.size() > 0) send_byte(tx_q.pop_front());
        tx_done = 1'b1;
    endtask

    task automatic collect(input bit stall, input int tail, input int max_cyc);
        int idle = 0;
        int hold = 0;
        bit fin = 1'b0;
        bit acc;
        op_beat_t e;
        op_beat_t g;
        n_err_op = 0;
        n_err_to = 0;
        to_delay = -1;
        since_done = 0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            acc = op_valid && op_ready;
            if (err_op) n_err_op++;
            if (err_to) begin
                n_err_to++;
                if (to_delay < 0) to_delay = since_done;
            end
            if (tx_done) since_done++;
            if (acc) begin
                checks++;
                g = '{data: op_data, opcode: op_opcode,
                      first: op_first, last: op_last};
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL beat: unexpected data=%h op=%h f=%b l=%b",
                             g.data, g.opcode, g.first, g.last);
                end else begin
                    e = sb.pop_front();
                    if (g !== e) begin
                        failures++;
                        $display("FAIL beat: got %h/%h/%b/%b want %h/%h/%b/%b",
                                 g.data, g.opcode, g.first, g.last,
                                 e.data, e.opcode, e.first, e.last);
                    end
                end
            end
            if (tx_done && sb.size() == 0 && !op_valid) idle++;
            else idle = 0;
            if (idle >= tail) begin
                fin = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            if (stall) begin
                if (acc) begin
                    op_ready = 1'b0;
                    hold = 20;
                end else if (hold > 0) begin
                    hold--;
                    if (hold == 0) op_ready = 1'b1;
                end
            end
        end
        if (!fin) begin
            checks++;
            failures++;
            $display("FAIL collect: budget expired, %0d beats outstanding",
                     sb.size());
        end
        op_ready = 1'b1;
    endtask

    task automatic run(input bit stall, input int tail, input int max_cyc);
        tx_done = 1'b0;
        stall_cycles = 0;
        fork
            drive_all();
            collect(stall, tail, max_cyc);
        join
    endtask

    task automatic chk_errs(input string name, input int eo, input int et);
        checks++;
        if (n_err_op !== eo || n_err_to !== et) begin
            failures++;
            $display("FAIL %s errs: got op=%0d to=%0d want op=%0d to=%0d",
                     name, n_err_op, n_err_to, eo, et);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset rx_ready: got %b want 1", rx_ready);
        end
        checks++;
        if (op_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset valid/busy: got %b/%b want 0/0", op_valid, busy);
        end
        checks++;
        if (err_op !== 1'b0 || err_to !== 1'b0) begin
            failures++;
            $display("FAIL reset errs: got %b/%b want 0/0", err_op, err_to);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        add_hdr(8'h10, 16'd2);
        add_word(32'd1);
        add_word(32'd2);
        exp_beat(32'd1, 8'h10, 1'b1, 1'b0);
        exp_beat(32'd2, 8'h10, 1'b0, 1'b1);
        run(1'b0, 3, 500);
        chk_errs("basic", 0, 0);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL basic busy: got %b want 0", busy);
        end
    endtask

    task automatic test_backpressure();
        add_hdr(8'h11, 16'd5);
        for (int i = 1; i <= 5; i++) begin
            add_word(32'(i));
            exp_beat(32'(i), 8'h11, i == 1, i == 5);
        end
        run(1'b1, 3, 2000);
        chk_errs("backpressure", 0, 0);
        checks++;
        if (stall_cycles == 0) begin
            failures++;
            $display("FAIL backpressure stall: got %0d stall cycles want >0",
                     stall_cycles);
        end
    endtask

    task automatic test_back_to_back();
        add_hdr(8'h10, 16'd2);
        add_word(32'hAAAA_0001);
        add_word(32'hAAAA_0002);
        add_hdr(8'h11, 16'd1);
        add_word(32'hBBBB_0001);
        exp_beat(32'hAAAA_0001, 8'h10, 1'b1, 1'b0);
        exp_beat(32'hAAAA_0002, 8'h10, 1'b0, 1'b1);
        exp_beat(32'hBBBB_0001, 8'h11, 1'b1, 1'b1);
        run(1'b1, 3, 1000);
        chk_errs("back_to_back", 0, 0);
    endtask

    task automatic test_unknown_op();
        add_hdr(8'h42, 16'd2);
        add_word(32'hDEAD_BEEF);
        add_word(32'h0BAD_F00D);
        add_hdr(8'h10, 16'd1);
        add_word(32'h1234_5678);
        exp_beat(32'h1234_5678, 8'h10, 1'b1, 1'b1);
        run(1'b0, 3, 500);
        chk_errs("unknown_op", 1, 0);
    endtask

    task automatic test_max_len();
        add_hdr(8'h10, MAXL + 16'd1);
        for (int i = 0; i <= int'(MAXL); i++) add_word(32'hFFFF_0000 + i);
        add_hdr(8'h11, 16'd1);
        add_word(32'hCAFE_BABE);
        exp_beat(32'hCAFE_BABE, 8'h11, 1'b1, 1'b1);
        run(1'b0, 3, 500);
        chk_errs("max_len", 1, 0);
    endtask

    task automatic test_timeout();
        add_hdr(8'h10, 16'd3);
        add_word(32'h4433_2211);
        tx_q.push_back(8'h55);
        exp_beat(32'h4433_2211, 8'h10, 1'b1, 1'b0);
        run(1'b0, TO + 10, 500);
        chk_errs("timeout", 0, 1);
        checks++;
        if (to_delay < TO || to_delay > TO + 2) begin
            failures++;
            $display("FAIL timeout delay: got %0d want %0d..%0d",
                     to_delay, TO, TO + 2);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout busy: got %b want 0", busy);
        end
        add_hdr(8'h11, 16'd1);
        add_word(32'h0F0F_0F0F);
        exp_beat(32'h0F0F_0F0F, 8'h11, 1'b1, 1'b1);
        run(1'b0, 3, 500);
        chk_errs("after_timeout", 0, 0);
    endtask

    task automatic test_reset_mid();
        add_hdr(8'h10, 16'd2);
        tx_q.push_back(8'h01);
        tx_q.push_back(8'h00);
        run(1'b0, 3, 200);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid busy before: got %b want 1", busy);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || op_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid busy/valid: got %b/%b want 0/0",
                     busy, op_valid);
        end
        rst_n = 1'b1;
        @(negedge clk);
        add_hdr(8'h10, 16'd2);
        add_word(32'h0000_000A);
        add_word(32'h0000_000B);
        exp_beat(32'h0000_000A, 8'h10, 1'b1, 1'b0);
        exp_beat(32'h0000_000B, 8'h10, 1'b0, 1'b1);
        run(1'b0, 3, 500);
        chk_errs("reset_mid", 0, 0);
    endtask

    task automatic test_len_zero();
        add_hdr(8'h10, 16'd0);
        run(1'b0, 3, 200);
        chk_errs("len_zero", 1, 0);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL len_zero busy: got %b want 0", busy);
        end
        add_hdr(8'h11, 16'd1);
        add_word(32'h0000_0077);
        exp_beat(32'h0000_0077, 8'h11, 1'b1, 1'b1);
        run(1'b0, 3, 500);
        chk_errs("after_len_zero", 0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_unknown_op();
        test_max_len();
        test_timeout();
        test_reset_mid();
        test_len_zero();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
